// File: rtl/reg_bank_if.sv
// Bus bundle for reg_bank: one-hot write/read selects, write data, the
// combinational read port A address and the status/error outputs.
interface reg_bank_if #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0]   x_write_en;
    logic [NREG-1:0]   x_read_en;
    logic [DATA_W-1:0] reg_b_wdata;
    logic [AW-1:0]     reg_a_addr;
    logic              err_clr;
    logic [DATA_W-1:0] reg_a_data;
    logic [DATA_W-1:0] reg_b_rdata;
    logic              reg_b_rvalid;
    logic [AW-1:0]     last_waddr;
    logic              onehot_err;
    logic [3:0]        err_cnt;

    // Bus owner side (drives selects and data, observes results)
    modport master (
        output x_write_en, x_read_en, reg_b_wdata, reg_a_addr, err_clr,
        input  reg_a_data, reg_b_rdata, reg_b_rvalid, last_waddr,
               onehot_err, err_cnt
    );

    // Register bank side
    modport slave (
        input  x_write_en, x_read_en, reg_b_wdata, reg_a_addr, err_clr,
        output reg_a_data, reg_b_rdata, reg_b_rvalid, last_waddr,
               onehot_err, err_cnt
    );
endinterface

// File: rtl/reg_bank.sv
// Eight-entry general-purpose register bank. Writes and port B reads use
// one-hot selects; selects with two or more bits set are rejected and
// flagged through a sticky error bit and a saturating error counter.
// Port A is a plain combinational read by binary address.
module reg_bank #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8
) (
    input  logic        clk,
    input  logic        rst,
    reg_bank_if.slave   bus
);
    localparam int AW = $clog2(NREG);
    localparam logic [3:0] CNT_MAX = 4'd15;

    // Exactly one bit set
    function automatic logic is_onehot(input logic [NREG-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Two or more bits set
    function automatic logic is_multi(input logic [NREG-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

    // Binary index of a one-hot vector (result meaningless otherwise)
    function automatic logic [AW-1:0] encode(input logic [NREG-1:0] v);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREG; i++) begin
            if (v[i]) idx = idx | AW'(i);
        end
        return idx;
    endfunction

    // Saturating increment of the error counter
    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == CNT_MAX) ? CNT_MAX : c + 4'd1;
    endfunction

    logic [DATA_W-1:0] r_regs [NREG];
    logic [DATA_W-1:0] r_rdata_p1;
    logic              r_rvld_p1;
    logic [AW-1:0]     r_last_waddr;
    logic              r_err;
    logic [3:0]        r_err_cnt;

    logic              w_wr_legal;
    logic              w_wr_illegal;
    logic              w_rd_legal;
    logic              w_rd_illegal;
    logic              w_illegal;
    logic [AW-1:0]     w_waddr;
    logic [AW-1:0]     w_raddr;
    logic              w_fwd;
    logic [DATA_W-1:0] w_rd_src;

    // Select classification and read-source selection with write-through
    always_comb begin
        w_wr_legal   = is_onehot(bus.x_write_en);
        w_wr_illegal = is_multi(bus.x_write_en);
        w_rd_legal   = is_onehot(bus.x_read_en);
        w_rd_illegal = is_multi(bus.x_read_en);
        w_illegal    = w_wr_illegal | w_rd_illegal;
        w_waddr      = encode(bus.x_write_en);
        w_raddr      = encode(bus.x_read_en);
        w_fwd        = w_wr_legal && (w_waddr == w_raddr);
        w_rd_src     = w_fwd ? bus.reg_b_wdata : r_regs[w_raddr];
    end

    // Storage and last-write address; illegal writes change nothing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_last_waddr <= '0;
        end else if (w_wr_legal) begin
            r_regs[w_waddr] <= bus.reg_b_wdata;
            r_last_waddr    <= w_waddr;
        end
    end

    // ---- read stage p1: port B data and its one-cycle valid ----
    // Port B read register; data holds when no legal read is requested
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata_p1 <= '0;
            r_rvld_p1  <= 1'b0;
        end else begin
            r_rvld_p1 <= w_rd_legal;
            if (w_rd_legal) r_rdata_p1 <= w_rd_src;
        end
    end

    // Error tracking; an illegal cycle wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_illegal) begin
            r_err     <= 1'b1;
            r_err_cnt <= bus.err_clr ? 4'd1 : sat_inc(r_err_cnt);
        end else if (bus.err_clr) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end
    end

    assign bus.reg_a_data   = r_regs[bus.reg_a_addr];
    assign bus.reg_b_rdata  = r_rdata_p1;
    assign bus.reg_b_rvalid = r_rvld_p1;
    assign bus.last_waddr   = r_last_waddr;
    assign bus.onehot_err   = r_err;
    assign bus.err_cnt      = r_err_cnt;
endmodule

// File: tb/tb_reg_bank.sv
// Randomised and directed bench for reg_bank against a behavioural model.
module tb_reg_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;

    reg_bank_if #(.DATA_W(8), .NREG(8)) bus ();

    reg_bank #(.DATA_W(8), .NREG(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [7:0] m_regs [8];
    logic [7:0] m_rdata;
    logic       m_rvalid;
    logic [2:0] m_last;
    logic       m_err;
    int         m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_rdata = 8'h00; m_rvalid = 1'b0; m_last = 3'd0; m_err = 1'b0; m_cnt = 0;
    endtask

    task automatic model_clock(input logic [7:0] we, input logic [7:0] re,
                               input logic [7:0] wd, input logic clr);
        int  nw, nr;
        logic bad;
        nw  = $countones(we);
        nr  = $countones(re);
        bad = (nw > 1) || (nr > 1);
        if (nw == 1) begin
            m_regs[$clog2(we)] = wd;
            m_last = 3'($clog2(we));
        end
        // Reading after the write gives the new value on a same-register hit
        m_rvalid = (nr == 1);
        if (nr == 1) m_rdata = m_regs[$clog2(re)];
        if (bad) begin
            m_err = 1'b1;
            m_cnt = clr ? 1 : ((m_cnt + 1 > 15) ? 15 : m_cnt + 1);
        end else if (clr) begin
            m_err = 1'b0;
            m_cnt = 0;
        end
    endtask

    task automatic check_outputs();
        check("rdata",  bus.reg_b_rdata,  m_rdata);
        check("rvalid", bus.reg_b_rvalid, m_rvalid);
        check("lastw",  bus.last_waddr,   m_last);
        check("err",    bus.onehot_err,   m_err);
        check("cnt",    bus.err_cnt,      m_cnt[3:0]);
    endtask

    // One clock cycle: drive, check port A before the edge, check after it
    task automatic step(input logic [7:0] we, input logic [7:0] re, input logic [7:0] wd,
                        input logic [2:0] aa, input logic clr);
        bus.x_write_en  = we;
        bus.x_read_en   = re;
        bus.reg_b_wdata = wd;
        bus.reg_a_addr  = aa;
        bus.err_clr     = clr;
        #1;
        check("rega", bus.reg_a_data, m_regs[aa]);
        @(posedge clk);
        model_clock(we, re, wd, clr);
        #1;
        check_outputs();
    endtask

    function automatic logic [7:0] rand_sel();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1, 2:    return 8'h01 << $urandom_range(0, 7);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        bus.x_write_en = '0; bus.x_read_en = '0; bus.reg_b_wdata = '0;
        bus.reg_a_addr = '0; bus.err_clr = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_outputs();
        check("rst_rega", bus.reg_a_data, 8'h00);
        rst = 1'b0;

        // Scenario 1: write r3, read it back
        step(8'h08, 8'h00, 8'hA5, 3'd3, 1'b0);
        check("s1_lastw", bus.last_waddr, 3'd3);
        step(8'h00, 8'h08, 8'h00, 3'd3, 1'b0);
        check("s1_rdata", bus.reg_b_rdata, 8'hA5);
        check("s1_rvld",  bus.reg_b_rvalid, 1'b1);
        check("s1_rega",  bus.reg_a_data, 8'hA5);
        step(8'h00, 8'h00, 8'h00, 3'd3, 1'b0);
        check("s1_pulse", bus.reg_b_rvalid, 1'b0);

        // Scenario 2: same-cycle write/read of r6 forwards the new value
        step(8'h40, 8'h00, 8'h11, 3'd6, 1'b0);
        step(8'h40, 8'h40, 8'h3C, 3'd6, 1'b0);
        check("s2_rdata", bus.reg_b_rdata, 8'h3C);
        check("s2_rvld",  bus.reg_b_rvalid, 1'b1);

        // Scenario 3: illegal write is suppressed
        step(8'h01, 8'h00, 8'h77, 3'd0, 1'b0);
        step(8'h05, 8'h00, 8'hFF, 3'd0, 1'b0);
        check("s3_err", bus.onehot_err, 1'b1);
        check("s3_cnt", bus.err_cnt, 4'd1);
        check("s3_lastw", bus.last_waddr, 3'd0);
        step(8'h00, 8'h00, 8'h00, 3'd2, 1'b0);
        check("s3_r0", m_regs[0] == 8'h77 && bus.onehot_err, 1'b1);

        // Scenario 4: 20 illegal reads saturate the counter, then clear+illegal
        for (int i = 0; i < 20; i++) step(8'h00, 8'h03, 8'h00, 3'd0, 1'b0);
        check("s4_cnt15", bus.err_cnt, 4'd15);
        check("s4_rvld", bus.reg_b_rvalid, 1'b0);
        step(8'h00, 8'h03, 8'h00, 3'd0, 1'b1);
        check("s4_cnt1", bus.err_cnt, 4'd1);
        check("s4_err1", bus.onehot_err, 1'b1);
        step(8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
        check("s4_clr", bus.err_cnt, 4'd0);

        // Scenario 6: preload, then back-to-back reads of r1..r3
        for (int i = 0; i < 8; i++) step(8'h01 << i, 8'h00, 8'(8'h10 + i), 3'(i), 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step(8'h00, 8'h01 << i, 8'h00, 3'(i), 1'b0);
            check("s6_rvld", bus.reg_b_rvalid, 1'b1);
            check("s6_rdata", bus.reg_b_rdata, 8'(8'h10 + i));
        end

        // Scenario 5: asynchronous reset during a read of r5
        step(8'h00, 8'h10, 8'h00, 3'd5, 1'b0);
        bus.x_read_en = 8'h20;
        bus.reg_a_addr = 3'd5;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("s5_rega", bus.reg_a_data, 8'h00);
        @(posedge clk); #1;
        bus.x_read_en = 8'h00;
        rst = 1'b0;
        step(8'h00, 8'h00, 8'h00, 3'd5, 1'b0);
        check("s5_norvld", bus.reg_b_rvalid, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 400; i++)
            step(rand_sel(), rand_sel(), 8'($urandom_range(0, 255)),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 x_write_en  input  8  one-hot write select; bit i targets register i.
REQ-005 x_read_en  input  8  one-hot read select for port B; bit i targets register i.
REQ-006 reg_b_wdata  input  8  write data for the selected register.
REQ-007 reg_a_addr  input  3  binary address, read port A.
REQ-008 err_clr  input  1  clears onehot_err and err_cnt.
REQ-009 reg_a_data  output  8  combinational read of register reg_a_addr.
REQ-010 reg_b_rdata  output  8  registered port B read data.
REQ-011 reg_b_rvalid  output  1  one-cycle pulse qualifying reg_b_rdata.
REQ-012 last_waddr  output  3  binary-encoded address of the last accepted write.
REQ-013 onehot_err  output  1  sticky illegal-select flag.
REQ-014 err_cnt  output  4  saturating count of illegal-select cycles.

Function
REQ-015 Storage SHALL be eight 8-bit registers, r0..r7, all general-purpose; r0 is not hardwired.
REQ-016 Select classification per vector, per cycle: none (all zero), legal (exactly one bit set), or illegal (two or more bits set).
REQ-017 A legal x_write_en SHALL write reg_b_wdata into the selected register at the rising edge.
REQ-018 A legal write SHALL load last_waddr with the encoded index at the same edge.
REQ-019 Write-none SHALL be a no-op.
REQ-020 An illegal x_write_en SHALL suppress the write entirely: no register changes and last_waddr holds.
REQ-021 A legal x_read_en SHALL load reg_b_rdata with the selected register at the edge and assert reg_b_rvalid for exactly the following cycle. Latency is 1 cycle.
REQ-022 Read/write same register, same cycle: reg_b_rdata SHALL return the new value reg_b_wdata (write-through forwarding).
REQ-023 Read-none or illegal read: reg_b_rvalid SHALL be 0 next cycle and reg_b_rdata SHALL hold its previous value.
REQ-024 reg_a_data SHALL reflect register contents combinationally, with no forwarding. A same-cycle write appears on reg_a_data after the edge.
REQ-025 Illegal write or illegal read in a cycle SHALL set onehot_err at that edge. Both illegal in the same cycle counts as one event.
REQ-026 Each illegal cycle SHALL increment err_cnt by 1, saturating at 15 with no wrap.
REQ-027 err_clr SHALL clear onehot_err and err_cnt at the edge.
REQ-028 If err_clr coincides with an illegal cycle, the result SHALL be onehot_err=1 and err_cnt=1 (set wins).
REQ-029 Back-to-back legal reads SHALL produce back-to-back rvalid pulses, one per request, with no bubbles.

Reset
REQ-030 rst assertion SHALL immediately, without waiting for a clock edge, force all of the following to zero: r0..r7=0x00, reg_b_rdata=0x00, reg_b_rvalid=0, last_waddr=0, onehot_err=0, err_cnt=0.
REQ-031 A reset during a pending read SHALL drop that read, so no rvalid appears after reset.
REQ-032 Operations SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-033 Scenario 1: write x_write_en=0x08 with wdata=0xA5, then read x_read_en=0x08 -> reg_b_rdata=0xA5, rvalid=1 for one cycle, last_waddr=3, reg_a_addr=3 gives 0xA5.
REQ-034 Scenario 2: same cycle x_write_en=0x40, x_read_en=0x40, wdata=0x3C (r6 previously 0x11) -> next cycle reg_b_rdata=0x3C, rvalid=1.
REQ-035 Scenario 3: x_write_en=0x05, wdata=0xFF -> r0 and r2 unchanged, last_waddr unchanged, onehot_err=1, err_cnt=1.
REQ-036 Scenario 4: 20 consecutive illegal x_read_en=0x03 cycles -> rvalid stays 0, err_cnt=15. Then err_clr plus one more illegal cycle -> onehot_err=1, err_cnt=1.
REQ-037 Scenario 5: after loading r0..r7 with 0x10..0x17, assert rst mid-cycle during a read of r5 -> all outputs 0 asynchronously, no rvalid after release, r5 reads 0x00.
REQ-038 Scenario 6: reads of r1, r2, r3 on consecutive cycles -> rvalid high for 3 consecutive cycles with data 0x11, 0x12, 0x13 (after Scenario 5's preload without reset).
